// File: rtl/fp32_mul_pipe.sv
// Five-stage pipelined IEEE-754 binary32 multiplier with a pipeline-wide clock enable.
// Denormal inputs flush to zero, round-to-nearest-even, no denormal outputs, no flags.
module fp32_mul_pipe #(
    parameter int LATENCY    = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic        clock,
    input  logic        aclr,
    input  logic        clk_en,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result
);

    // Result classes carried down the pipe alongside the normal-path data
    localparam logic [1:0] KIND_NORM = 2'd0;
    localparam logic [1:0] KIND_NAN  = 2'd1;
    localparam logic [1:0] KIND_INF  = 2'd2;
    localparam logic [1:0] KIND_ZERO = 2'd3;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // ---------------- S1 unpack / classify (combinational front) ----------------
    logic [7:0]  exp_a, exp_b;
    logic [22:0] frac_a, frac_b;
    logic        zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
    logic [1:0]  kind_in;

    always_comb begin
        exp_a  = dataa[30:23];
        exp_b  = datab[30:23];
        frac_a = dataa[22:0];
        frac_b = datab[22:0];
        // exp==0 covers both true zero and flushed denormals
        zero_a = (exp_a == 8'h00);
        zero_b = (exp_b == 8'h00);
        inf_a  = (exp_a == 8'hFF) && (frac_a == '0);
        inf_b  = (exp_b == 8'hFF) && (frac_b == '0);
        nan_a  = (exp_a == 8'hFF) && (frac_a != '0);
        nan_b  = (exp_b == 8'hFF) && (frac_b != '0);
        if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a))
            kind_in = KIND_NAN;
        else if (inf_a || inf_b)
            kind_in = KIND_INF;
        else if (zero_a || zero_b)
            kind_in = KIND_ZERO;
        else
            kind_in = KIND_NORM;
    end

    logic        s1_sign;
    logic [1:0]  s1_kind;
    logic [7:0]  s1_exp_a, s1_exp_b;
    logic [23:0] s1_sig_a, s1_sig_b;

    // ---------------- S2 multiply / exponent add ----------------
    logic        s2_sign;
    logic [1:0]  s2_kind;
    logic signed [9:0] s2_exp;
    logic [47:0] s2_prod;

    logic signed [9:0] exp_sum;
    always_comb begin
        exp_sum = $signed({2'b00, s1_exp_a}) + $signed({2'b00, s1_exp_b}) - 10'sd127;
    end

    // ---------------- S3 normalize ----------------
    logic        s3_sign;
    logic [1:0]  s3_kind;
    logic signed [9:0] s3_exp;
    logic [23:0] s3_sig;
    logic        s3_guard;
    logic        s3_sticky;

    logic [23:0] norm_sig;
    logic        norm_guard, norm_sticky;
    logic signed [9:0] norm_exp;
    always_comb begin
        if (s2_prod[47]) begin
            norm_sig    = s2_prod[47:24];
            norm_guard  = s2_prod[23];
            norm_sticky = |s2_prod[22:0];
            norm_exp    = s2_exp + 10'sd1;
        end else begin
            norm_sig    = s2_prod[46:23];
            norm_guard  = s2_prod[22];
            norm_sticky = |s2_prod[21:0];
            norm_exp    = s2_exp;
        end
    end

    // ---------------- S4 round / range check ----------------
    logic        s4_sign;
    logic [1:0]  s4_kind;
    logic [7:0]  s4_exp;
    logic [22:0] s4_frac;

    logic [24:0] rnd_sum;
    logic        rnd_up;
    logic signed [9:0] rnd_exp;
    logic [22:0] rnd_frac;
    logic [1:0]  rnd_kind;
    always_comb begin
        rnd_up   = s3_guard && (s3_sticky || s3_sig[0]);
        rnd_sum  = {1'b0, s3_sig} + {24'd0, rnd_up};
        rnd_exp  = s3_exp;
        rnd_frac = rnd_sum[22:0];
        // Carry out of the significand: value is exactly 2.0 x 2^e, so mantissa is zero
        if (rnd_sum[24]) begin
            rnd_exp  = s3_exp + 10'sd1;
            rnd_frac = '0;
        end
        rnd_kind = s3_kind;
        if (s3_kind == KIND_NORM) begin
            if (s3_exp <= 10'sd0)
                rnd_kind = KIND_ZERO;
            else if (rnd_exp >= 10'sd255)
                rnd_kind = KIND_INF;
        end
    end

    // ---------------- S5 pack ----------------
    logic [31:0] packed_word;
    always_comb begin
        case (s4_kind)
            KIND_NAN:  packed_word = QNAN;
            KIND_INF:  packed_word = {s4_sign, 8'hFF, 23'd0};
            KIND_ZERO: packed_word = {s4_sign, 31'd0};
            default:   packed_word = {s4_sign, s4_exp, s4_frac};
        endcase
    end

    always_ff @(posedge clock) begin
        if (aclr) begin
            s1_sign   <= 1'b0;
            s1_kind   <= KIND_NORM;
            s1_exp_a  <= '0;
            s1_exp_b  <= '0;
            s1_sig_a  <= '0;
            s1_sig_b  <= '0;
            s2_sign   <= 1'b0;
            s2_kind   <= KIND_NORM;
            s2_exp    <= '0;
            s2_prod   <= '0;
            s3_sign   <= 1'b0;
            s3_kind   <= KIND_NORM;
            s3_exp    <= '0;
            s3_sig    <= '0;
            s3_guard  <= 1'b0;
            s3_sticky <= 1'b0;
            s4_sign   <= 1'b0;
            s4_kind   <= KIND_NORM;
            s4_exp    <= '0;
            s4_frac   <= '0;
            result    <= '0;
        end else if (clk_en) begin
            s1_sign   <= dataa[31] ^ datab[31];
            s1_kind   <= kind_in;
            s1_exp_a  <= exp_a;
            s1_exp_b  <= exp_b;
            s1_sig_a  <= {1'b1, frac_a};
            s1_sig_b  <= {1'b1, frac_b};

            s2_sign   <= s1_sign;
            s2_kind   <= s1_kind;
            s2_exp    <= exp_sum;
            s2_prod   <= s1_sig_a * s1_sig_b;

            s3_sign   <= s2_sign;
            s3_kind   <= s2_kind;
            s3_exp    <= norm_exp;
            s3_sig    <= norm_sig;
            s3_guard  <= norm_guard;
            s3_sticky <= norm_sticky;

            s4_sign   <= s3_sign;
            s4_kind   <= rnd_kind;
            s4_exp    <= rnd_exp[7:0];
            s4_frac   <= rnd_frac;

            result    <= packed_word;
        end
    end

endmodule

// File: tb/tb_fp32_mul_pipe.sv
// Directed self-checking bench for fp32_mul_pipe: latency, streaming, specials,
// rounding, stall and reset behaviour with hand-computed binary32 results.
module tb_fp32_mul_pipe;

    logic        clock = 1'b0;
    logic        aclr = 1'b0;
    logic        clk_en = 1'b0;
    logic [31:0] dataa = '0;
    logic [31:0] datab = '0;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    fp32_mul_pipe #(.LATENCY(5), .DATA_WIDTH(32)) dut (
        .clock (clock),
        .aclr  (aclr),
        .clk_en(clk_en),
        .dataa (dataa),
        .datab (datab),
        .result(result)
    );

    always #5 clock = ~clock;

    // Advance one rising edge; inputs change and outputs are sampled 1ns after it
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        aclr = 1'b1; clk_en = 1'b1; dataa = 32'h4000_0000; datab = 32'h4040_0000;
        tick(); tick(); tick();
        checks++;
        if (result !== 32'h0000_0000) begin
            errors++;
            $display("FAIL reset_state: got %08h expected 00000000", result);
        end
        aclr = 1'b0; dataa = '0; datab = '0;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (result !== 32'h0000_0000) begin
            errors++;
            $display("FAIL reset_idle_zeros: got %08h expected 00000000", result);
        end
    endtask

    task automatic test_basic_latency();
        clk_en = 1'b1;
        dataa = 32'h4000_0000; datab = 32'h4040_0000;
        tick();                          // edge N samples the operands
        dataa = '0; datab = '0;
        tick(); tick(); tick();          // edges N+1..N+3
        checks++;
        if (result !== 32'h0000_0000) begin
            errors++;
            $display("FAIL latency_early: got %08h expected 00000000", result);
        end
        tick();                          // edge N+4
        checks++;
        if (result !== 32'h40C0_0000) begin
            errors++;
            $display("FAIL latency_product: got %08h expected 40c00000", result);
        end
        tick();
        checks++;
        if (result !== 32'h0000_0000) begin
            errors++;
            $display("FAIL latency_next_zero: got %08h expected 00000000", result);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] va [3] = '{32'h3FC0_0000, 32'hC000_0000, 32'h3F80_0001};
        logic [31:0] vb [3] = '{32'h3FC0_0000, 32'h3F00_0000, 32'h3F80_0001};
        logic [31:0] ve [3] = '{32'h4010_0000, 32'hBF80_0000, 32'h3F80_0002};
        clk_en = 1'b1;
        for (int t = 0; t < 7; t++) begin
            if (t < 3) begin dataa = va[t]; datab = vb[t]; end
            else       begin dataa = '0;    datab = '0;    end
            tick();
            if (t >= 4) begin
                checks++;
                if (result !== ve[t-4]) begin
                    errors++;
                    $display("FAIL back_to_back[%0d]: got %08h expected %08h", t-4, result, ve[t-4]);
                end
            end
        end
    endtask

    // Specials, range limits and rounding ties streamed one pair per cycle
    task automatic test_specials();
        logic [31:0] va [13] = '{
            32'h7F00_0000, 32'h7F80_0000, 32'h0000_0001, 32'h8000_0000,
            32'h7FC1_2345, 32'hFF80_0000, 32'h0080_0000, 32'h7F00_0000,
            32'h7F00_0000, 32'h3F80_0001, 32'h3F80_0003, 32'h3FFF_FFFF,
            32'h0000_0000};
        logic [31:0] vb [13] = '{
            32'h7F00_0000, 32'h0000_0000, 32'h3F80_0000, 32'h4000_0000,
            32'h3F80_0000, 32'hC000_0000, 32'h0080_0000, 32'h4000_0000,
            32'h3F80_0000, 32'h3FC0_0000, 32'h3FC0_0000, 32'h3FFF_FFFF,
            32'h7F80_0000};
        logic [31:0] ve [13] = '{
            32'h7F80_0000, 32'h7FC0_0000, 32'h0000_0000, 32'h8000_0000,
            32'h7FC0_0000, 32'h7F80_0000, 32'h0000_0000, 32'h7F80_0000,
            32'h7F00_0000, 32'h3FC0_0002, 32'h3FC0_0004, 32'h407F_FFFE,
            32'h7FC0_0000};
        clk_en = 1'b1;
        for (int t = 0; t < 17; t++) begin
            if (t < 13) begin dataa = va[t]; datab = vb[t]; end
            else        begin dataa = '0;    datab = '0;    end
            tick();
            if (t >= 4) begin
                checks++;
                if (result !== ve[t-4]) begin
                    errors++;
                    $display("FAIL special[%0d] %08h*%08h: got %08h expected %08h",
                             t-4, va[t-4], vb[t-4], result, ve[t-4]);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic held_ok = 1'b1;
        clk_en = 1'b1;
        for (int i = 0; i < 5; i++) tick();   // drain to a zero result
        dataa = 32'h4000_0000; datab = 32'h4040_0000;
        tick();                               // edge 1 (sample)
        dataa = '0; datab = '0;
        tick();                               // edge 2
        clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin     // edges 3..5 stalled
            dataa = 32'h4100_0000; datab = 32'h4100_0000;
            tick();
            if (result !== 32'h0000_0000) held_ok = 1'b0;
        end
        dataa = '0; datab = '0;
        clk_en = 1'b1;
        tick(); tick();                       // edges 6, 7
        checks++;
        if (!held_ok || result !== 32'h0000_0000) begin
            errors++;
            $display("FAIL stall_early: got %08h expected 00000000 (held=%0d)", result, held_ok);
        end
        tick();                               // edge 8
        checks++;
        if (result !== 32'h40C0_0000) begin
            errors++;
            $display("FAIL stall_product: got %08h expected 40c00000", result);
        end
        clk_en = 1'b0;
        tick(); tick();
        checks++;
        if (result !== 32'h40C0_0000) begin
            errors++;
            $display("FAIL stall_hold_result: got %08h expected 40c00000", result);
        end
        clk_en = 1'b1;
        tick();
        checks++;
        if (result !== 32'h0000_0000) begin
            errors++;
            $display("FAIL stall_resume: got %08h expected 00000000", result);
        end
    endtask

    task automatic test_reset_mid();
        logic clean = 1'b1;
        clk_en = 1'b1;
        dataa = 32'h4000_0000; datab = 32'h4040_0000;
        tick();                               // edge 1 (sample)
        dataa = '0; datab = '0;
        aclr = 1'b1; clk_en = 1'b0;           // reset must win over a low enable
        tick();                               // edge 2
        aclr = 1'b0; clk_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (result !== 32'h0000_0000) clean = 1'b0;
        end
        checks++;
        if (!clean) begin
            errors++;
            $display("FAIL reset_mid_discard: got nonzero result, last %08h expected 00000000", result);
        end
        dataa = 32'h3FC0_0000; datab = 32'h3FC0_0000;
        tick();
        dataa = '0; datab = '0;
        tick(); tick(); tick(); tick();
        checks++;
        if (result !== 32'h4010_0000) begin
            errors++;
            $display("FAIL reset_mid_recover: got %08h expected 40100000", result);
        end
    endtask

    initial begin
        test_reset();
        test_basic_latency();
        test_back_to_back();
        test_specials();
        test_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
